// File: rtl/rvga_types_pkg.sv
// Shared RVGA datapath types: word/mask aliases, dmem responder FSM states and a lane-merge helper.
package rvga_types;

  typedef logic [31:0] rvga_word;
  typedef logic [3:0]  rvga_wmask;

  typedef enum logic [1:0] {
    RVGA_DMEM_CLEAR = 2'd0,
    RVGA_DMEM_IDLE  = 2'd1,
    RVGA_DMEM_BUSY  = 2'd2,
    RVGA_DMEM_DONE  = 2'd3
  } rvga_dmem_state_e;

  function automatic rvga_word rvga_apply_wmask(input rvga_word old_w,
                                                input rvga_word new_w,
                                                input rvga_wmask mask);
    rvga_word res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_responder_bank.sv
// words_p x 32 data array: byte-masked synchronous write, registered or combinational read.
module dmem_bank
  import rvga_types::*;
#(
  parameter int words_p    = 1024,
  parameter bit reg_read_p = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [$clog2(words_p)-1:0] widx_i,
  input  rvga_word                   wdata_i,
  input  rvga_wmask                  wmask_i,
  input  logic                       re_i,
  input  logic [$clog2(words_p)-1:0] ridx_i,
  output rvga_word                   rdata_o
);

  rvga_word mem [words_p];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[widx_i] <= rvga_apply_wmask(mem[widx_i], wdata_i, wmask_i);
  end

  // Registered read samples the pre-write word when read and write share an edge.
  if (reg_read_p) begin : g_reg_read
    rvga_word rdata_r;
    always_ff @(posedge clk_i) begin
      if (rst_i)     rdata_r <= '0;
      else if (re_i) rdata_r <= mem[ridx_i];
    end
    assign rdata_o = rdata_r;
  end else begin : g_comb_read
    logic unused_ctrl;
    assign unused_ctrl = ^{rst_i, re_i};
    assign rdata_o     = mem[ridx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one read/masked write per request with latency_p wait states.
// Optional RVGA_DMEM_CLEAR_EN: zero the whole array after reset before accepting requests.
module dmem_responder
  import rvga_types::*;
#(
  parameter int words_p   = 1024,
  parameter int latency_p = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      dmem_r_v_i,
  input  logic      dmem_w_v_i,
  input  rvga_word  dmem_addr_i,
  input  rvga_word  dmem_data_i,
  input  rvga_wmask dmem_wmask_i,
  output rvga_word  dmem_data_o,
  output logic      stall_v_o
);

  localparam int idx_w = $clog2(words_p);
  localparam int cnt_w = (latency_p < 2) ? 1 : $clog2(latency_p);

  localparam logic [1:0] ST_CLEAR = RVGA_DMEM_CLEAR;
  localparam logic [1:0] ST_IDLE  = RVGA_DMEM_IDLE;
  localparam logic [1:0] ST_BUSY  = RVGA_DMEM_BUSY;
  localparam logic [1:0] ST_DONE  = RVGA_DMEM_DONE;

`ifdef RVGA_DMEM_CLEAR_EN
  localparam logic [1:0] ST_RESET = ST_CLEAR;
  logic [idx_w-1:0] clr_idx_r;
`else
  localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

  logic [1:0]       state_r;
  logic [cnt_w-1:0] cnt_r;
  logic             req;
  logic [idx_w-1:0] req_idx;
  logic             go_done;

  logic [idx_w-1:0] cap_idx_p0;
  rvga_word         cap_data_p0;
  rvga_wmask        cap_mask_p0;
  logic             cap_w_p0;

  logic             bank_we;
  logic [idx_w-1:0] bank_idx;
  rvga_word         bank_data;
  rvga_wmask        bank_mask;
  rvga_word         bank_rdata;

  logic unused_addr;
  assign unused_addr = ^{dmem_addr_i[1:0], dmem_addr_i[31:2+idx_w]};

  assign req     = dmem_r_v_i | dmem_w_v_i;
  assign req_idx = dmem_addr_i[2 +: idx_w];

  // The edge that enters DONE commits the access; reset at that edge aborts it.
  assign go_done = !rst_i && (latency_p != 0) &&
                   (((state_r == ST_BUSY) && (cnt_r == cnt_w'(1))) ||
                    ((state_r == ST_IDLE) && req && (latency_p == 1)));

  always_comb begin
    unique case (state_r)
      ST_IDLE: stall_v_o = (latency_p != 0) && req;
      ST_BUSY: stall_v_o = 1'b1;
      ST_DONE: stall_v_o = 1'b0;
      default: stall_v_o = 1'b1;
    endcase
  end

  always_comb begin
    bank_we   = 1'b0;
    bank_idx  = cap_idx_p0;
    bank_data = cap_data_p0;
    bank_mask = cap_mask_p0;
    if (latency_p == 0) begin
      bank_we   = (state_r == ST_IDLE) && dmem_w_v_i && !rst_i;
      bank_idx  = req_idx;
      bank_data = dmem_data_i;
      bank_mask = dmem_wmask_i;
    end else if (go_done) begin
      if (state_r == ST_IDLE) begin
        bank_we   = dmem_w_v_i;
        bank_idx  = req_idx;
        bank_data = dmem_data_i;
        bank_mask = dmem_wmask_i;
      end else begin
        bank_we = cap_w_p0;
      end
    end
`ifdef RVGA_DMEM_CLEAR_EN
    if (state_r == ST_CLEAR) begin
      bank_we   = !rst_i;
      bank_idx  = clr_idx_r;
      bank_data = '0;
      bank_mask = '1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_RESET;
      cnt_r   <= '0;
`ifdef RVGA_DMEM_CLEAR_EN
      clr_idx_r <= '0;
`endif
    end else begin
      unique case (state_r)
        ST_IDLE: begin
          if (req && (latency_p != 0)) begin
            cnt_r   <= cnt_w'(latency_p - 1);
            state_r <= (latency_p == 1) ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r - cnt_w'(1);
          if (cnt_r == cnt_w'(1)) state_r <= ST_DONE;
        end
        ST_DONE: state_r <= ST_IDLE;
`ifdef RVGA_DMEM_CLEAR_EN
        ST_CLEAR: begin
          clr_idx_r <= clr_idx_r + idx_w'(1);
          if (clr_idx_r == idx_w'(words_p - 1)) state_r <= ST_IDLE;
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Capture stage: request fields held for the remainder of the wait states.
  always_ff @(posedge clk_i) begin
    if ((state_r == ST_IDLE) && req) begin
      cap_idx_p0  <= req_idx;
      cap_data_p0 <= dmem_data_i;
      cap_mask_p0 <= dmem_wmask_i;
      cap_w_p0    <= dmem_w_v_i;
    end
  end

  dmem_bank #(
    .words_p    (words_p),
    .reg_read_p (latency_p != 0)
  ) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (bank_we),
    .widx_i  (bank_idx),
    .wdata_i (bank_data),
    .wmask_i (bank_mask),
    .re_i    (go_done),
    .ridx_i  (bank_idx),
    .rdata_o (bank_rdata)
  );

  assign dmem_data_o = bank_rdata;

endmodule
